mul16_seq_ctrl: RTL

Sequencer that computes a 16x16 unsigned product by time-multiplexing one external 8x8 combinational Dadda multiplier over four passes. Each pass drives one pair of operand bytes and accumulates the shifted partial product into a 32-bit register. The block provides a start/busy/done handshake toward the requesting datapath. The 8x8 multiplier is instantiated beside this block and connected through the mul_* ports.

---
 rtl/mul16_seq_ctrl_if.sv | 23 ++
 rtl/mul16_seq_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mul16_seq_ctrl_if.sv
// Request/result bundle between a requesting datapath and the 16x16 multiply sequencer.
// The requester drives the operands and start/abort; the sequencer returns busy/done/p.
interface mul16_seq_ctrl_if #(
    parameter int HALF = 8
);
    logic                start;
    logic                abort;
    logic [2*HALF-1:0]   a;
    logic [2*HALF-1:0]   b;
    logic                busy;
    logic                done;
    logic [4*HALF-1:0]   p;

    modport master (
        output start, abort, a, b,
        input  busy, done, p
    );

    modport slave (
        input  start, abort, a, b,
        output busy, done, p
    );
endinterface

// File: rtl/mul16_seq_ctrl.sv
// Four-pass 16x16 unsigned multiply sequencer that time-shares one external
// combinational 8x8 multiplier, accumulating the shifted partial products.
module mul16_seq_ctrl #(
    parameter int HALF = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mul16_seq_ctrl_if.slave   bus,
    output logic [HALF-1:0]   mul_a_o,
    output logic [HALF-1:0]   mul_b_o,
    input  logic [2*HALF-1:0] mul_p_i
);

    typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, DONE} state_e;

    state_e              state_q, state_d;
    logic [2*HALF-1:0]   opA_q, opA_d, opB_q, opB_d;
    logic [4*HALF-1:0]   acc_q, acc_d, p_q, p_d;
    logic [HALF-1:0]     mulA_q, mulA_d, mulB_q, mulB_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [4*HALF-1:0]   prodExt;

    assign prodExt = {{(2*HALF){1'b0}}, mul_p_i};

    // Outputs are decoded from the next state so they are registered and
    // already valid during the first cycle of each pass.
    always_comb begin
        state_d = state_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        acc_d   = acc_q;
        p_d     = p_q;
        mulA_d  = '0;
        mulB_d  = '0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    opA_d   = bus.a;
                    opB_d   = bus.b;
                    acc_d   = '0;
                    state_d = P0;
                end
            end
            P0: begin
                acc_d   = acc_q + prodExt;
                state_d = P1;
            end
            P1: begin
                acc_d   = acc_q + (prodExt << HALF);
                state_d = P2;
            end
            P2: begin
                acc_d   = acc_q + (prodExt << HALF);
                state_d = P3;
            end
            P3: begin
                acc_d   = acc_q + (prodExt << (2*HALF));
                p_d     = acc_d;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
            p_d     = p_q;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);

        case (state_d)
            P0: begin
                mulA_d = opA_d[HALF-1:0];
                mulB_d = opB_d[HALF-1:0];
            end
            P1: begin
                mulA_d = opA_d[HALF-1:0];
                mulB_d = opB_d[2*HALF-1:HALF];
            end
            P2: begin
                mulA_d = opA_d[2*HALF-1:HALF];
                mulB_d = opB_d[HALF-1:0];
            end
            P3: begin
                mulA_d = opA_d[2*HALF-1:HALF];
                mulB_d = opB_d[2*HALF-1:HALF];
            end
            default: begin
                mulA_d = '0;
                mulB_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opA_q   <= '0;
            opB_q   <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            mulA_q  <= '0;
            mulB_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            mulA_q  <= mulA_d;
            mulB_q  <= mulB_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.p    = p_q;
    assign mul_a_o  = mulA_q;
    assign mul_b_o  = mulB_q;

endmodule
